// File: rtl/id_ex_stage.sv
`default_nettype none
//============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with a valid/ready handshake, flush,
//            bubble-safe control outputs and ALU operand selection.
//            With ID_EX_FORWARD_EN defined, rs1/rs2 operands are forwarded
//            from the EX/MEM and MEM/WB result buses (MEM wins, x0 never
//            forwarded), and held operands are refreshed every stall cycle.
// Config   : `define ID_EX_FORWARD_EN -> operand forwarding + hold refresh
// Ports    : clk, rst_n (async, active-low)
//            id_valid/id_ready        decode-side handshake
//            id_* operands/controls   decoded instruction fields
//            ex_ready, flush          downstream accept, stage kill
//            mem_fwd_*, wb_fwd_*      forwarding sources
//            ex_valid, aluin1/2, aluCtrl, ex_rd_addr, ex_reg_we, ex_pc,
//            ex_rs2_data              execute-side outputs
// Revision : 1.0  initial release
//============================================================================

`ifndef ALUCTRL_ADD
`define ALUCTRL_ADD 4'd0
`endif

module id_ex_stage #(
    parameter logic [3:0] RESET_ALUCTRL = `ALUCTRL_ADD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [3:0]  id_alu_ctrl,
    input  logic        id_src1_pc,
    input  logic        id_src2_imm,
    input  logic        id_reg_we,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        mem_fwd_we,
    input  logic [4:0]  mem_fwd_rd,
    input  logic [31:0] mem_fwd_data,
    input  logic        wb_fwd_we,
    input  logic [4:0]  wb_fwd_rd,
    input  logic [31:0] wb_fwd_data,
    output logic        ex_valid,
    output logic [31:0] aluin1,
    output logic [31:0] aluin2,
    output logic [3:0]  aluCtrl,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_we,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs2_data
);

    // Stage registers
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1_addr;
    logic [4:0]  r_rs2_addr;
    logic [4:0]  r_rd_addr;
    logic [3:0]  r_alu_ctrl;
    logic        r_src1_pc;
    logic        r_src2_imm;
    logic        r_reg_we;

    logic        w_load;
    logic        w_hold;
    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;

    assign id_ready = (!r_valid || ex_ready) && !flush;
    assign w_load   = id_valid && id_ready;
    assign w_hold   = r_valid && !ex_ready && !flush;

`ifdef ID_EX_FORWARD_EN
    // MEM result is younger than WB, so it takes priority; x0 is hardwired.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (mem_fwd_we && (mem_fwd_rd == r_rs1_addr) && (r_rs1_addr != 5'd0))
            w_fwd_rs1 = mem_fwd_data;
        else if (wb_fwd_we && (wb_fwd_rd == r_rs1_addr) && (r_rs1_addr != 5'd0))
            w_fwd_rs1 = wb_fwd_data;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (mem_fwd_we && (mem_fwd_rd == r_rs2_addr) && (r_rs2_addr != 5'd0))
            w_fwd_rs2 = mem_fwd_data;
        else if (wb_fwd_we && (wb_fwd_rd == r_rs2_addr) && (r_rs2_addr != 5'd0))
            w_fwd_rs2 = wb_fwd_data;
    end
`else
    // Decode stalls resolve hazards; forwarding buses and indices are unused.
    assign w_fwd_rs1 = r_rs1_data;
    assign w_fwd_rs2 = r_rs2_data;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                            wb_fwd_we, wb_fwd_rd, wb_fwd_data,
                            r_rs1_addr, r_rs2_addr};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_rs1_addr <= 5'd0;
            r_rs2_addr <= 5'd0;
            r_rd_addr  <= 5'd0;
            r_alu_ctrl <= RESET_ALUCTRL;
            r_src1_pc  <= 1'b0;
            r_src2_imm <= 1'b0;
            r_reg_we   <= 1'b0;
        end else if (flush) begin
            // Kill overrides both load and hold; id_ready is low so nothing enters.
            r_valid  <= 1'b0;
            r_reg_we <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1_addr <= id_rs1_addr;
            r_rs2_addr <= id_rs2_addr;
            r_rd_addr  <= id_rd_addr;
            r_alu_ctrl <= id_alu_ctrl;
            r_src1_pc  <= id_src1_pc;
            r_src2_imm <= id_src2_imm;
            r_reg_we   <= id_reg_we;
        end else if (w_hold) begin
`ifdef ID_EX_FORWARD_EN
            // Capture any producer that retires while we are stalled.
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
`endif
        end else begin
            // Drained downstream (or idle) with nothing new accepted.
            r_valid <= 1'b0;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rd_addr  = r_rd_addr;
    // Bubbles present a harmless default operation and never write back.
    assign aluCtrl     = r_valid ? r_alu_ctrl : RESET_ALUCTRL;
    assign ex_reg_we   = r_valid && r_reg_we;
    assign aluin1      = r_src1_pc  ? r_pc  : w_fwd_rs1;
    assign aluin2      = r_src2_imm ? r_imm : w_fwd_rs2;
    assign ex_rs2_data = w_fwd_rs2;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
//============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage. Accepted instructions are
//            pushed to a scoreboard queue; a monitor pops and compares when
//            the stage hands an instruction downstream. Stall, forwarding,
//            flush and asynchronous reset behaviour are checked directly.
// Revision : 1.0  initial release
//============================================================================
module tb_id_ex_stage;

    localparam logic [3:0] RESET_CTRL = 4'd0;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda;
        logic [3:0]  ctrl;
        logic        s1pc, s2imm, we;
    } instr_t;

    typedef struct {
        logic [31:0] a1, a2, pc, rs2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic        id_src1_pc, id_src2_imm, id_reg_we;
    logic        ex_ready, flush;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        ex_valid, ex_reg_we;
    logic [31:0] aluin1, aluin2, ex_pc, ex_rs2_data;
    logic [3:0]  aluCtrl;
    logic [4:0]  ex_rd_addr;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_alu_ctrl(id_alu_ctrl),
        .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm), .id_reg_we(id_reg_we),
        .ex_ready(ex_ready), .flush(flush),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_valid(ex_valid), .aluin1(aluin1), .aluin2(aluin2), .aluCtrl(aluCtrl),
        .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_pc(ex_pc),
        .ex_rs2_data(ex_rs2_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input instr_t i);
        exp_t e;
        e.a1   = i.s1pc  ? i.pc  : i.rs1d;
        e.a2   = i.s2imm ? i.imm : i.rs2d;
        e.pc   = i.pc;
        e.rs2  = i.rs2d;
        e.ctrl = i.ctrl;
        e.rd   = i.rda;
        e.we   = i.we;
        return e;
    endfunction

    task automatic drive(input instr_t i);
        id_valid    = 1'b1;
        id_pc       = i.pc;
        id_rs1_data = i.rs1d;
        id_rs2_data = i.rs2d;
        id_imm      = i.imm;
        id_rs1_addr = i.rs1a;
        id_rs2_addr = i.rs2a;
        id_rd_addr  = i.rda;
        id_alu_ctrl = i.ctrl;
        id_src1_pc  = i.s1pc;
        id_src2_imm = i.s2imm;
        id_reg_we   = i.we;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Downstream transfer happens at the next edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_aluin1", aluin1, e.a1);
                chk("sb_aluin2", aluin2, e.a2);
                chk("sb_aluCtrl", {28'd0, aluCtrl}, {28'd0, e.ctrl});
                chk("sb_rd", {27'd0, ex_rd_addr}, {27'd0, e.rd});
                chk("sb_reg_we", {31'd0, ex_reg_we}, {31'd0, e.we});
                chk("sb_pc", ex_pc, e.pc);
                chk("sb_rs2_data", ex_rs2_data, e.rs2);
            end
        end
    end

    instr_t a, b, c;

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; flush = 1'b0;
        id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_alu_ctrl = '0;
        id_src1_pc = 1'b0; id_src2_imm = 1'b0; id_reg_we = 1'b0;
        mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_fwd_we = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_reg_we", {31'd0, ex_reg_we}, 32'd0);
        chk("rst_aluCtrl", {28'd0, aluCtrl}, {28'd0, RESET_CTRL});
        chk("rst_aluin1", aluin1, 32'd0);
        chk("rst_aluin2", aluin2, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        step();
        rst_n = 1'b1;

        // addi: rs1=5, imm=7
        step();
        a = '{pc:32'h100, rs1d:32'd5, rs2d:32'd9, imm:32'd7, rs1a:5'd1, rs2a:5'd2,
              rda:5'd3, ctrl:4'd0, s1pc:1'b0, s2imm:1'b1, we:1'b1};
        drive(a); ex_ready = 1'b1; sb_q.push_back(model(a));
        @(negedge clk);
        chk("addi_id_ready", {31'd0, id_ready}, 32'd1);

        // Back-to-back random instructions at full throughput
        for (int k = 0; k < 6; k++) begin
            step();
            b.pc = $urandom; b.rs1d = $urandom; b.rs2d = $urandom; b.imm = $urandom;
            b.rs1a = 5'($urandom); b.rs2a = 5'($urandom); b.rda = 5'($urandom);
            b.ctrl = 4'($urandom); b.s1pc = 1'($urandom); b.s2imm = 1'($urandom);
            b.we = 1'($urandom);
            drive(b); sb_q.push_back(model(b));
            @(negedge clk);
            chk("tput_id_ready", {31'd0, id_ready}, 32'd1);
        end
        step();
        id_valid = 1'b0;
        step();
        @(negedge clk);
        chk("drain_ex_valid", {31'd0, ex_valid}, 32'd0);

        // Stall for 3 cycles with a second instruction waiting
        step();
        a = '{pc:32'h200, rs1d:32'h11, rs2d:32'h22, imm:32'h33, rs1a:5'd5, rs2a:5'd6,
              rda:5'd7, ctrl:4'd2, s1pc:1'b1, s2imm:1'b0, we:1'b1};
        drive(a); sb_q.push_back(model(a));
        step();
        b = '{pc:32'h204, rs1d:32'h44, rs2d:32'h55, imm:32'h66, rs1a:5'd8, rs2a:5'd9,
              rda:5'd10, ctrl:4'd4, s1pc:1'b0, s2imm:1'b1, we:1'b0};
        drive(b); ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_id_ready", {31'd0, id_ready}, 32'd0);
            chk("stall_pc", ex_pc, 32'h200);
            chk("stall_aluin1", aluin1, 32'h200);
            step();
        end
        ex_ready = 1'b1; sb_q.push_back(model(b));
        @(negedge clk);
        chk("unstall_id_ready", {31'd0, id_ready}, 32'd1);
        step();
        id_valid = 1'b0;
        step();
        ex_ready = 1'b0;

        // Forwarding priority on a held instruction (rs1=3)
        c = '{pc:32'h400, rs1d:32'h11, rs2d:32'h22, imm:32'h0, rs1a:5'd3, rs2a:5'd9,
              rda:5'd12, ctrl:4'd5, s1pc:1'b0, s2imm:1'b0, we:1'b1};
        drive(c);
        step();
        id_valid = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'hAAAA;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd3; wb_fwd_data  = 32'hBBBB;
        @(negedge clk);
        chk("fwd_mem_priority", aluin1, FWD ? 32'hAAAA : 32'h11);
        chk("held_reg_we", {31'd0, ex_reg_we}, 32'd1);
        chk("held_aluCtrl", {28'd0, aluCtrl}, 32'd5);
        step();
        mem_fwd_we = 1'b0;
        @(negedge clk);
        chk("fwd_wb_only", aluin1, FWD ? 32'hBBBB : 32'h11);
        step();
        wb_fwd_we = 1'b0;
        @(negedge clk);
        chk("fwd_refreshed_rs1", aluin1, FWD ? 32'hBBBB : 32'h11);

        // Flush with a valid instruction waiting upstream
        step();
        a.pc = 32'h500;
        drive(a); flush = 1'b1;
        @(negedge clk);
        chk("flush_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        flush = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush_reg_we", {31'd0, ex_reg_we}, 32'd0);
        chk("flush_aluCtrl", {28'd0, aluCtrl}, {28'd0, RESET_CTRL});
        step();
        @(negedge clk);
        chk("flush_not_taken", {31'd0, ex_valid}, 32'd0);

        // x0 never forwarded; mid-stall WB producer on rs2=4
        step();
        c = '{pc:32'h600, rs1d:32'h0, rs2d:32'h55, imm:32'h0, rs1a:5'd0, rs2a:5'd4,
              rda:5'd13, ctrl:4'd3, s1pc:1'b0, s2imm:1'b0, we:1'b1};
        drive(c);
        step();
        id_valid = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hCCCC;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'hDDDD;
        @(negedge clk);
        chk("fwd_x0_blocked", aluin1, 32'd0);
        step();
        mem_fwd_we = 1'b0;
        wb_fwd_rd = 5'd4; wb_fwd_data = 32'h1234;
        @(negedge clk);
        chk("wb_fwd_rs2", ex_rs2_data, FWD ? 32'h1234 : 32'h55);
        chk("wb_fwd_aluin2", aluin2, FWD ? 32'h1234 : 32'h55);
        step();
        wb_fwd_we = 1'b0;
        @(negedge clk);
        chk("hold_refresh_rs2", ex_rs2_data, FWD ? 32'h1234 : 32'h55);
        chk("hold_aluin1_x0", aluin1, 32'd0);

        // Asynchronous reset in the middle of a stall
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_reg_we", {31'd0, ex_reg_we}, 32'd0);
        chk("arst_aluCtrl", {28'd0, aluCtrl}, {28'd0, RESET_CTRL});
        chk("arst_aluin1", aluin1, 32'd0);
        chk("arst_aluin2", aluin2, 32'd0);
        chk("arst_rs2_data", ex_rs2_data, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        step();
        rst_n = 1'b1;

        // First edge after reset release may load
        a = '{pc:32'h700, rs1d:32'h77, rs2d:32'h88, imm:32'h99, rs1a:5'd1, rs2a:5'd2,
              rda:5'd14, ctrl:4'd6, s1pc:1'b0, s2imm:1'b1, we:1'b1};
        drive(a); ex_ready = 1'b1; sb_q.push_back(model(a));
        step();
        id_valid = 1'b0;
        step();
        @(negedge clk);
        chk("sb_all_retired", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter RESET_ALUCTRL, default `ALUCTRL_ADD, aluCtrl value held in reset and in bubbles.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1 / id_ready  output  1  decode-side handshake.
REQ-005 id_pc, id_rs1_data, id_rs2_data, id_imm  input  32 each  decoded operands.
REQ-006 id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  register indices.
REQ-007 id_alu_ctrl  input  4  ALU operation; id_src1_pc  input  1  (1: operand1=pc); id_src2_imm  input  1  (1: operand2=imm); id_reg_we  input  1.
REQ-008 ex_ready  input  1  downstream accepts current instruction; flush  input  1  kill stage contents.
REQ-009 mem_fwd_we  input  1, mem_fwd_rd  input  5, mem_fwd_data  input  32  EX/MEM forwarding source.
REQ-010 wb_fwd_we  input  1, wb_fwd_rd  input  5, wb_fwd_data  input  32  MEM/WB forwarding source.
REQ-011 ex_valid  output  1; aluin1, aluin2  output  32; aluCtrl  output  4; ex_rd_addr  output  5; ex_reg_we  output  1; ex_pc  output  32; ex_rs2_data  output  32 (store data, forwarded).

Function
REQ-012 id_ready SHALL equal (!ex_valid || ex_ready) && !flush, combinationally.
REQ-013 Load: when id_valid && id_ready, SHALL capture all id_* fields next edge and set ex_valid=1.
REQ-014 Drain: when ex_ready && !(id_valid && id_ready), SHALL clear ex_valid next edge.
REQ-015 Hold: when ex_valid && !ex_ready && !flush, SHALL retain pc, imm, indices, control; rs1/rs2 data refreshed per REQ-019.
REQ-016 Flush SHALL clear ex_valid and ex_reg_we next edge, overriding load and hold; incoming id instruction not accepted that cycle.
REQ-017 When ex_valid=0, aluCtrl SHALL be RESET_ALUCTRL and ex_reg_we 0 (bubble is harmless).
REQ-018 Operand select: aluin1 = src1_pc ? ex_pc : fwd_rs1; aluin2 = src2_imm ? imm : fwd_rs2; ex_rs2_data = fwd_rs2; combinational from stage registers, zero added latency.
REQ-019 Forwarding (under FORWARD_EN): fwd_rsN = mem data if mem_fwd_we && mem_fwd_rd==rsN && rsN!=0, else wb data if wb_fwd_we && wb_fwd_rd==rsN && rsN!=0, else registered data; MEM beats WB when both match; x0 never forwarded. During hold, registered rsN data SHALL be overwritten with fwd_rsN each cycle so a producer retiring mid-stall is not lost.
REQ-020 One instruction in flight max; latency id accept -> ex_valid = 1 cycle; full throughput when ex_ready=1 every cycle.
REQ-021 No arithmetic; all paths 32-bit pass/mux only.

Reset
REQ-022 rst_n low SHALL immediately force ex_valid=0, ex_reg_we=0, ex_pc/imm/rs data/indices=0, aluCtrl=RESET_ALUCTRL, src selects=0; aluin1=aluin2=0.
REQ-023 Reset mid-stall SHALL discard held instruction; first edge after rst_n rises may load.

Configuration
REQ-024 Macro ID_EX_FORWARD_EN defined: REQ-019 forwarding and hold-refresh active.
REQ-025 ID_EX_FORWARD_EN undefined: fwd_rsN = registered data, mem_/wb_fwd_* ignored, no hold-refresh; hazards resolved by decode stalls.

Verification
REQ-026 Load addi: rs1_data=5, imm=7, src2_imm=1, alu_ctrl=ADD, ex_ready=1 -> next cycle ex_valid=1, aluin1=5, aluin2=7, id_ready=1.
REQ-027 Stall: ex_ready=0 for 3 cycles with id_valid=1 -> id_ready=0, outputs frozen, second instruction appears one cycle after ex_ready returns.
REQ-028 Forward priority: rs1=3, mem rd=3 data=0xAAAA, wb rd=3 data=0xBBBB -> aluin1=0xAAAA; mem rd=0 with rs1=0 -> aluin1=registered 0.
REQ-029 Mid-stall WB: hold with rs2=4, wb rd=4 data=0x1234 one cycle then deasserted -> ex_rs2_data stays 0x1234 after (FORWARD_EN); without macro stays original.
REQ-030 Flush with id_valid=1 and ex_valid=1 -> next cycle ex_valid=0, ex_reg_we=0, aluCtrl=RESET_ALUCTRL, id instruction not taken.
REQ-031 Assert rst_n=0 asynchronously mid-stall -> outputs reach reset values without clock edge.
